// File: rtl/ls_reg_file.sv
// ls_reg_file: DEPTH x WIDTH working register bank.
// One addressed write port (load / increment / decrement / clear entry),
// two combinational read ports, and a whole-bank shadow copy that can be
// captured (snap) or restored (rest). ovf records any inc/dec wrap and
// stays set until cleared.
module ls_reg_file #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             set,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    ra0,
    input  logic [AW-1:0]    ra1,
    input  logic             snap,
    input  logic             rest,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [DEPTH-1:0] vld,
    output logic             ovf
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic signed [WIDTH-1:0] bank_q   [DEPTH];
    logic signed [WIDTH-1:0] bank_d   [DEPTH];
    logic signed [WIDTH-1:0] shadow_q [DEPTH];
    logic signed [WIDTH-1:0] shadow_d [DEPTH];
    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0]        vld_d;
    logic [DEPTH-1:0]        shadow_vld_q;
    logic [DEPTH-1:0]        shadow_vld_d;
    logic                    ovf_q;
    logic                    ovf_d;

    // Increment modulo 2^WIDTH; the top bit of the result flags the wrap
    // from all-ones to zero.
    function automatic logic [WIDTH:0] wrap_inc(input logic [WIDTH-1:0] v);
        return {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
    endfunction

    // Decrement modulo 2^WIDTH; the top bit of the result flags the borrow
    // out of zero, i.e. the wrap to all-ones.
    function automatic logic [WIDTH:0] wrap_dec(input logic [WIDTH-1:0] v);
        return {1'b0, v} - {{WIDTH{1'b0}}, 1'b1};
    endfunction

    // Next-state: restore beats write beats hold; snap always captures the
    // pre-edge bank so a same-cycle write or restore is never captured.
    always_comb begin
        logic [WIDTH:0] res;
        logic           wrap;
        bank_d       = bank_q;
        vld_d        = vld_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        res          = '0;
        wrap         = 1'b0;

        if (rest) begin
            bank_d = shadow_q;
            vld_d  = shadow_vld_q;
        end else if (set) begin
            unique case (op)
                OP_LOAD: begin
                    bank_d[wa] = in;
                    vld_d[wa]  = 1'b1;
                end
                OP_INC: begin
                    res        = wrap_inc(bank_q[wa]);
                    bank_d[wa] = res[WIDTH-1:0];
                    vld_d[wa]  = 1'b1;
                    wrap       = res[WIDTH];
                end
                OP_DEC: begin
                    res        = wrap_dec(bank_q[wa]);
                    bank_d[wa] = res[WIDTH-1:0];
                    vld_d[wa]  = 1'b1;
                    wrap       = res[WIDTH];
                end
                OP_CLR: begin
                    bank_d[wa] = '0;
                    vld_d[wa]  = 1'b0;
                end
                default: begin
                    bank_d = bank_q;
                end
            endcase
        end

        if (snap) begin
            shadow_d     = bank_q;
            shadow_vld_d = vld_q;
        end

        // A wrap in the same cycle as ovf_clr leaves the flag set.
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wrap) begin
            ovf_d = 1'b1;
        end
    end

    // State registers; clr low clears bank, shadow and flags at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            vld_q        <= '0;
            shadow_vld_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            shadow_q     <= shadow_d;
            vld_q        <= vld_d;
            shadow_vld_q <= shadow_vld_d;
            ovf_q        <= ovf_d;
        end
    end

    // Read ports are plain muxes with no write bypass.
    always_comb begin
        out0 = bank_q[ra0];
        out1 = bank_q[ra1];
    end

    assign vld = vld_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_ls_reg_file.sv
// Scoreboard bench for ls_reg_file: stimulus pushes expected post-edge
// outputs into a queue at the falling edge; a monitor pops and compares
// after every rising edge and after an asynchronous clr assertion.
module tb_ls_reg_file;

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] INC = 2'b01;
    localparam logic [1:0] DEC = 2'b10;
    localparam logic [1:0] CLE = 2'b11;

    typedef struct packed {
        logic [3:0] o0;
        logic [3:0] o1;
        logic [3:0] v;
        logic       f;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       set = 1'b0;
    logic [1:0] op = 2'b00;
    logic [1:0] wa = 2'b00;
    logic [3:0] din = 4'h0;
    logic [1:0] ra0 = 2'b00;
    logic [1:0] ra1 = 2'b00;
    logic       snap = 1'b0;
    logic       rest = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] out0;
    logic [3:0] out1;
    logic [3:0] vld;
    logic       ovf;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail = 0;

    ls_reg_file #(.WIDTH(4), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .clr(clr), .set(set), .op(op), .wa(wa), .in(din),
        .ra0(ra0), .ra1(ra1), .snap(snap), .rest(rest), .ovf_clr(ovf_clr),
        .out0(out0), .out1(out1), .vld(vld), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // Monitor: compare after each rising edge and after clr falls.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk or negedge clr);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if (out0 !== e.o0 || out1 !== e.o1 || vld !== e.v || ovf !== e.f) begin
                    n_fail++;
                    $display("FAIL %s: got out0=%h out1=%h vld=%b ovf=%b, want out0=%h out1=%h vld=%b ovf=%b",
                             nm, out0, out1, vld, ovf, e.o0, e.o1, e.v, e.f);
                end
            end
        end
    end

    task automatic push(input logic [3:0] e0, input logic [3:0] e1,
                        input logic [3:0] ev, input logic eo, input string nm);
        exp_t e;
        e.o0 = e0; e.o1 = e1; e.v = ev; e.f = eo;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the
    // outputs expected after the following rising edge.
    task automatic step(input logic s, input logic [1:0] o, input logic [1:0] a,
                        input logic [3:0] d, input logic [1:0] r0, input logic [1:0] r1,
                        input logic sn, input logic re, input logic oc,
                        input logic [3:0] e0, input logic [3:0] e1,
                        input logic [3:0] ev, input logic eo, input string nm);
        @(negedge clk);
        set = s; op = o; wa = a; din = d; ra0 = r0; ra1 = r1;
        snap = sn; rest = re; ovf_clr = oc;
        push(e0, e1, ev, eo, nm);
    endtask

    // Pull clr low mid-cycle, expect everything at zero before the next
    // edge, then release on the following falling edge.
    task automatic async_reset(input string nm);
        @(negedge clk);
        set = 1'b0; snap = 1'b0; rest = 1'b0; ovf_clr = 1'b0;
        push(4'h0, 4'h0, 4'b0000, 1'b0, nm);
        #2 clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        #2 push(4'h0, 4'h0, 4'b0000, 1'b0, "reset_state");
        @(negedge clk);
        clr = 1'b1;

        // reset mid-cycle after a write
        step(1, LD, 2, 4'hA, 2, 2, 0, 0, 0, 4'hA, 4'hA, 4'b0100, 0, "load_a_e2");
        ra0 = 2'd2;
        async_reset("clr_async");

        // load and hold
        step(1, LD,  1, 4'h5, 1, 1, 0, 0, 0, 4'h5, 4'h5, 4'b0010, 0, "load5_e1");
        step(0, INC, 1, 4'hF, 1, 0, 0, 0, 0, 4'h5, 4'h0, 4'b0010, 0, "hold_1");
        step(0, INC, 3, 4'hF, 1, 0, 0, 0, 0, 4'h5, 4'h0, 4'b0010, 0, "hold_2");
        step(0, INC, 1, 4'h3, 1, 0, 0, 0, 0, 4'h5, 4'h0, 4'b0010, 0, "hold_3");

        // increment wrap and sticky ovf
        step(1, LD,  3, 4'hF, 3, 1, 0, 0, 0, 4'hF, 4'h5, 4'b1010, 0, "loadF_e3");
        step(1, INC, 3, 4'h0, 3, 1, 0, 0, 0, 4'h0, 4'h5, 4'b1010, 1, "inc_wrap");
        step(1, DEC, 3, 4'h0, 3, 1, 0, 0, 1, 4'hF, 4'h5, 4'b1010, 1, "dec_wrap_with_ovf_clr");
        step(0, LD,  0, 4'h0, 3, 1, 0, 0, 1, 4'hF, 4'h5, 4'b1010, 0, "ovf_clr_alone");
        step(1, INC, 1, 4'h0, 1, 3, 0, 0, 0, 4'h6, 4'hF, 4'b1010, 0, "inc_nowrap");
        step(1, DEC, 1, 4'h0, 1, 3, 0, 0, 0, 4'h5, 4'hF, 4'b1010, 0, "dec_nowrap");

        // clear entry
        step(1, LD,  0, 4'h7, 0, 1, 0, 0, 0, 4'h7, 4'h5, 4'b1011, 0, "load7_e0");
        step(1, CLE, 0, 4'h9, 0, 1, 0, 0, 0, 4'h0, 4'h5, 4'b1010, 0, "clear_e0");
        step(0, LD,  0, 4'h0, 3, 1, 0, 0, 0, 4'hF, 4'h5, 4'b1010, 0, "others_kept");

        // snapshot / restore
        step(1, LD,  0, 4'h1, 0, 1, 0, 0, 0, 4'h1, 4'h5, 4'b1011, 0, "ld1_e0");
        step(1, LD,  1, 4'h2, 0, 1, 0, 0, 0, 4'h1, 4'h2, 4'b1011, 0, "ld2_e1");
        step(1, LD,  2, 4'h3, 2, 3, 0, 0, 0, 4'h3, 4'hF, 4'b1111, 0, "ld3_e2");
        step(1, LD,  3, 4'h4, 2, 3, 0, 0, 0, 4'h3, 4'h4, 4'b1111, 0, "ld4_e3");
        step(1, LD,  0, 4'h9, 0, 1, 1, 0, 0, 4'h9, 4'h2, 4'b1111, 0, "snap_with_load");
        step(1, CLE, 2, 4'h0, 2, 0, 0, 0, 0, 4'h0, 4'h9, 4'b1011, 0, "clear_e2");
        step(1, LD,  1, 4'hC, 0, 1, 0, 1, 0, 4'h1, 4'h2, 4'b1111, 0, "rest_drops_write");
        step(0, LD,  0, 4'h0, 2, 3, 0, 0, 0, 4'h3, 4'h4, 4'b1111, 0, "restored_e2_e3");

        // snap + rest swap with an all-zero shadow
        async_reset("clr_async_2");
        step(1, LD,  0, 4'h1, 0, 0, 0, 0, 0, 4'h1, 4'h1, 4'b0001, 0, "swap_ld_e0");
        step(1, LD,  1, 4'h2, 0, 1, 0, 0, 0, 4'h1, 4'h2, 4'b0011, 0, "swap_ld_e1");
        step(1, LD,  2, 4'h3, 2, 1, 0, 0, 0, 4'h3, 4'h2, 4'b0111, 0, "swap_ld_e2");
        step(1, LD,  3, 4'h4, 2, 3, 0, 0, 0, 4'h3, 4'h4, 4'b1111, 0, "swap_ld_e3");
        step(0, LD,  0, 4'h0, 0, 3, 1, 1, 0, 4'h0, 4'h0, 4'b0000, 0, "swap");
        // dropped wrapping decrement must not raise ovf
        step(1, DEC, 0, 4'h0, 0, 3, 0, 1, 0, 4'h1, 4'h4, 4'b1111, 0, "rest_after_swap");
        step(0, LD,  0, 4'h0, 1, 2, 0, 0, 0, 4'h2, 4'h3, 4'b1111, 0, "rest_after_swap_e1_e2");

        // decrement wrap from zero
        step(1, CLE, 0, 4'h0, 0, 1, 0, 0, 0, 4'h0, 4'h2, 4'b1110, 0, "clear_e0_again");
        step(1, DEC, 0, 4'h0, 0, 0, 0, 0, 0, 4'hF, 4'hF, 4'b1111, 1, "dec_wrap");

        @(negedge clk);
        set = 1'b0; snap = 1'b0; rest = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
